udma_rx_wr_arbiter: RTL

Parametrised next-generation uDMA RX write path. It arbitrates up to N_CH peripheral RX streams, each carrying its own pre-computed byte address, into one buffered L2 write port. It steers byte lanes for 32/64/128-bit L2 and supports selectable round-robin or fixed-priority arbitration. Misaligned beats are detected, dropped and reported. It sits between the per-channel address generators and the L2 interconnect port.

---
 rtl/udma_rx_wr_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/udma_rx_wr_arbiter.sv
// udma_rx_wr_arbiter: arbitrates N_CH RX beats into a buffered, lane-steered L2 write port
module udma_rx_wr_arbiter #(
  parameter int N_CH           = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int L2_DATA_WIDTH  = 64,
  parameter int L2_AWIDTH_NOAL = 35,
  parameter int FIFO_DEPTH     = 4,
  parameter int ARB_MODE       = 0,
  localparam int LB = $clog2(L2_DATA_WIDTH / 8),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                      clk_i,
  input  logic                                      rstn_i,
  input  logic [N_CH-1:0]                           ch_valid_i,
  input  logic [N_CH-1:0][DATA_WIDTH-1:0]           ch_data_i,
  input  logic [N_CH-1:0][1:0]                      ch_datasize_i,
  input  logic [N_CH-1:0][L2_AWIDTH_NOAL-1:0]       ch_addr_i,
  output logic [N_CH-1:0]                           ch_ready_o,
  output logic                                      l2_req_o,
  input  logic                                      l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-LB-1:0]              l2_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]                l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]                  l2_wdata_o,
  output logic                                      misalign_o,
  output logic [CW-1:0]                             misalign_ch_o,
  output logic [LW-1:0]                             fifo_level_o,
  output logic                                      busy_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NB = L2_DATA_WIDTH / 8;
  logic [CW-1:0] ptr_q, ptr_d, mis_ch_q, mis_ch_d, gidx;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic mis_q, mis_d, found, accept, legal, push, pop, empty;
  logic [1:0] sz, h_size, lm;
  logic [L2_AWIDTH_NOAL-1:0] ad, h_addr;
  logic [DATA_WIDTH-1:0] dt, h_data, dmask;
  logic [3:0] bmask;
  logic [LB-1:0] off;
  logic [L2_AWIDTH_NOAL-1:0] addr_mem [FIFO_DEPTH];
  logic [1:0] size_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  // Search order starts at the pointer for round-robin, at index 0 for fixed priority
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = (ARB_MODE != 0) ? k : (int'(ptr_q) + k) % N_CH;
      if (!found && ch_valid_i[j]) begin
        found = 1'b1;
        gidx = CW'(j);
      end
    end
  end
  always_comb begin
    accept = found && (level_q < LW'(FIFO_DEPTH));
    ch_ready_o = accept ? (N_CH'(1) << gidx) : '0;
    sz = ch_datasize_i[gidx];
    ad = ch_addr_i[gidx];
    dt = ch_data_i[gidx];
    legal = (sz == 2'd0) | ((sz == 2'd1) & ~ad[0]) | ((sz == 2'd2) & (ad[1:0] == 2'b00));
    push = accept & legal;
    empty = (level_q == '0);
    pop = ~empty & l2_gnt_i;
    ptr_d = accept ? ((gidx == CW'(N_CH - 1)) ? '0 : gidx + 1'b1) : ptr_q;
    mis_d = accept & ~legal;
    mis_ch_d = mis_d ? gidx : mis_ch_q;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
      mis_q <= 1'b0;
      mis_ch_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      mis_q <= mis_d;
      mis_ch_q <= mis_ch_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_q] <= ad;
      size_mem[wr_q] <= sz;
      data_mem[wr_q] <= dt;
    end
  end
  // Head decode: offset is rounded down to the beat size, unused lanes stay zero
  always_comb begin
    h_addr = addr_mem[rd_q];
    h_size = size_mem[rd_q];
    h_data = data_mem[rd_q];
    lm = (h_size == 2'd0) ? 2'd0 : (h_size == 2'd1) ? 2'd1 : 2'd3;
    bmask = (h_size == 2'd0) ? 4'h1 : (h_size == 2'd1) ? 4'h3 : 4'hF;
    dmask = (h_size == 2'd0) ? 32'h0000_00FF : (h_size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    off = h_addr[LB-1:0] & ~LB'(lm);
    l2_be_o = empty ? '0 : (NB'(bmask) << off);
    l2_wdata_o = empty ? '0 : (L2_DATA_WIDTH'(h_data & dmask) << {off, 3'b000});
    l2_addr_o = empty ? '0 : h_addr[L2_AWIDTH_NOAL-1:LB];
    l2_req_o = ~empty;
    busy_o = ~empty;
    fifo_level_o = level_q;
    misalign_o = mis_q;
    misalign_ch_o = mis_ch_q;
  end
endmodule
